// File: rtl/alu32_arb.sv
// alu32_arb: two-requester, one-at-a-time 32-bit ALU with an IDLE/EXEC/DONE
// handshake FSM. Optional round-robin arbitration is enabled by defining
// ALU32_ARB_RR_EN; without it port 0 has fixed priority.
module alu32_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_flags
);

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_DEC  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ADF  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_CMPU = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_id;
  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic        w_accept;
  logic [31:0] w_x;
  logic [31:0] w_y;
  logic        w_cin;
  logic [32:0] w_sum;
  logic        w_ovf;
  logic [31:0] w_res;
  logic [2:0]  w_flags;

  assign w_gnt_valid = req0_valid | req1_valid;
  assign w_accept    = (r_state == ST_IDLE) && w_gnt_valid;

`ifdef ALU32_ARB_RR_EN
  logic r_last;

  // Grant: on contention pick the port not served last, otherwise whoever asks
  always_comb begin
    if (req0_valid && req1_valid) w_gnt_id = ~r_last;
    else                          w_gnt_id = ~req0_valid;
  end

  // Remember which port won the most recent handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last <= 1'b1;
    else if (w_accept) r_last <= w_gnt_id;
  end
`else
  // Grant: fixed priority, port 0 wins whenever it is valid
  always_comb begin
    w_gnt_id = ~req0_valid;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: accept -> one execute cycle -> hold until consumed
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_next = ST_EXEC;
      ST_EXEC:                w_state_next = ST_DONE;
      ST_DONE: if (rsp_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: ready only in IDLE and only toward the granted port
  always_comb begin
    req0_ready = (r_state == ST_IDLE) && w_gnt_valid && !w_gnt_id;
    req1_ready = (r_state == ST_IDLE) && w_gnt_valid &&  w_gnt_id;
  end

  // Capture operation and owner on the handshake edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 3'd0;
      r_a  <= 32'd0;
      r_b  <= 32'd0;
      r_id <= 1'b0;
    end else if (w_accept) begin
      r_op <= w_gnt_id ? req1_op : req0_op;
      r_a  <= w_gnt_id ? req1_a  : req0_a;
      r_b  <= w_gnt_id ? req1_b  : req0_b;
      r_id <= w_gnt_id;
    end
  end

  // Shared adder: SUB computes b + ~a + 1 so carry means "no borrow"
  always_comb begin
    w_x   = r_a;
    w_y   = r_b;
    w_cin = 1'b0;
    if (r_op == OP_SUB) begin
      w_x   = r_b;
      w_y   = ~r_a;
      w_cin = 1'b1;
    end
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};
    w_ovf = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
  end

  // Result and flags {carry, overflow, zero}; reserved ops pass a through
  always_comb begin
    w_res   = r_a;
    w_flags = 3'b000;
    case (r_op)
      OP_INC: w_res = r_a + 32'd1;
      OP_DEC: w_res = r_a - 32'd1;
      OP_ADD: w_res = w_sum[31:0];
      OP_ADF, OP_SUB: begin
        w_res   = w_sum[31:0];
        w_flags = {w_sum[32], w_ovf, (w_sum[31:0] == 32'd0)};
      end
      OP_CMPU: begin
        w_res = 32'd0;
        if (r_a == r_b)     w_flags = 3'b001;
        else if (r_a < r_b) w_flags = 3'b100;
        else                w_flags = 3'b010;
      end
      default: w_res = r_a;
    endcase
  end

  // Response registers: load in EXEC, hold through DONE until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_flags <= 3'd0;
      rsp_id    <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= w_res;
      rsp_flags <= w_flags;
      rsp_id    <= r_id;
    end else if (r_state == ST_DONE && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu32_arb.sv
// Scoreboard bench for alu32_arb: stimulus pushes expected responses, a
// negedge monitor pops and compares each consumed response.
module tb_alu32_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_pop  = 0;

  alu32_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare every response at the moment it is consumed
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual id=%0d data=%h flags=%b required none",
                 rsp_id, rsp_data, rsp_flags);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        $display("rsp id=%0d data=%h flags=%b (exp id=%0d data=%h flags=%b)",
                 rsp_id, rsp_data, rsp_flags, e.id, e.data, e.flags);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_flags", {29'd0, rsp_flags}, {29'd0, e.flags});
      end
    end
  end

  task automatic push(input logic id, input logic [31:0] data, input logic [2:0] flags);
    exp_t e;
    e.id = id; e.data = data; e.flags = flags;
    sb.push_back(e);
  endtask

  // Present a request and hold it until granted; returns just after the handshake edge
  task automatic drive(input logic port, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bit got;
    got = 0;
    if (!port) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = port ? req1_ready : req0_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL handshake_timeout port=%0d actual=no_ready required=ready", port);
    end
    @(posedge clk); #1;
    if (!port) req0_valid = 1'b0;
    else       req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout actual pending=%0d required pending=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input logic port, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] data, input logic [2:0] flags);
    push(port, data, flags);
    drive(port, op, a, b);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_flags", {29'd0, rsp_flags}, 32'd0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First op with latency check: valid must rise one cycle after the handshake
    push(1'b0, 32'd12, 3'b000);
    drive(1'b0, 3'd2, 32'd5, 32'd7);
    @(negedge clk); chk("lat_exec_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); chk("lat_done_valid", {31'd0, rsp_valid}, 32'd1);
    wait_idle();

    // Directed vectors: port, op, a, b, data, flags{carry,ovf,zero}
    run_vec(1'b0, 3'd3, 32'h7FFFFFFF, 32'd1, 32'h80000000, 3'b010);
    run_vec(1'b0, 3'd3, 32'hFFFFFFFF, 32'd1, 32'h00000000, 3'b101);
    run_vec(1'b0, 3'd5, 32'd3, 32'd3, 32'd0, 3'b001);
    run_vec(1'b0, 3'd5, 32'd2, 32'd9, 32'd0, 3'b100);
    run_vec(1'b0, 3'd5, 32'd9, 32'd2, 32'd0, 3'b010);
    run_vec(1'b0, 3'd4, 32'd2, 32'd9, 32'd7, 3'b100);
    run_vec(1'b0, 3'd4, 32'd5, 32'd5, 32'd0, 3'b101);
    run_vec(1'b0, 3'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 3'b000);
    run_vec(1'b0, 3'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 3'b000);
    run_vec(1'b0, 3'd2, 32'hFFFFFFFF, 32'd2, 32'd1, 3'b000);
    run_vec(1'b0, 3'd6, 32'h00001234, 32'd9, 32'h00001234, 3'b000);
    run_vec(1'b1, 3'd1, 32'd5, 32'd0, 32'd4, 3'b000);

    // Both ports valid continuously; last grant was port 1
`ifdef ALU32_ARB_RR_EN
    push(1'b0, 32'd2, 3'b000); push(1'b1, 32'd20, 3'b000);
    push(1'b0, 32'd2, 3'b000); push(1'b1, 32'd20, 3'b000);
`else
    repeat (4) push(1'b0, 32'd2, 3'b000);
`endif
    target = n_pop + 4;
    req0_valid = 1; req0_op = 3'd2; req0_a = 32'd1;  req0_b = 32'd1;
    req1_valid = 1; req1_op = 3'd2; req1_a = 32'd10; req1_b = 32'd10;
    for (int c = 0; c < 100 && n_pop < target; c++) begin
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Backpressure: hold rsp_ready low for 5 cycles while others wait
    rsp_ready = 1'b0;
    push(1'b0, 32'd7, 3'b100);
    drive(1'b0, 3'd4, 32'd2, 32'd9);
    for (int c = 0; c < 10 && rsp_valid !== 1'b1; c++) @(negedge clk);
    @(posedge clk); #1;
    push(1'b0, 32'd0, 3'b000);
    req0_valid = 1; req0_op = 3'd0; req0_a = 32'hFFFFFFFF; req0_b = 32'd0;
    req1_valid = 1; req1_op = 3'd2; req1_a = 32'd100; req1_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, 32'd7);
      chk("stall_flags", {29'd0, rsp_flags}, 32'd4);
      chk("stall_id", {31'd0, rsp_id}, 32'd0);
      chk("stall_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(posedge clk); #1;
      if (i == 1) req1_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_no_early_accept", {30'd0, req1_ready, req0_ready}, 32'd0);
    begin
      bit got;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        got = req0_ready;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL post_release_accept actual=no_ready required=ready");
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
    end
    wait_idle();

    // Reset during EXEC discards the operation
    drive(1'b0, 3'd2, 32'd3, 32'd4);
    rst_n = 1'b0;
    #2;
    chk("rst_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_exec_data", rsp_data, 32'd0);
    chk("rst_exec_flags", {29'd0, rsp_flags}, 32'd0);
    chk("rst_exec_id", {31'd0, rsp_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    run_vec(1'b0, 3'd2, 32'd20, 32'd22, 32'd42, 3'b000);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
